// File: rtl/godai_trace_pkg.sv
// rtl/godai_trace_pkg.sv - shared constants for the Godai trace recorder
package godai_trace_pkg;

   localparam int FLAG_JUMP   = 0;
   localparam int FLAG_BRDEC  = 1;
   localparam int FLAG_PCSET  = 2;
   localparam int FLAG_BRREQ  = 3;
   localparam int FLAG_DECODE = 4;
   localparam int FLAG_MEM    = 5;
   localparam int FLAG_RSVD   = 6;
   localparam int FLAG_OVF    = 7;

   localparam int REC_FLAGS_LSB = 0;
   localparam int REC_MEM_LSB   = 8;

   function automatic int rec_instr_lsb(input int cnt_w);
      return REC_MEM_LSB + cnt_w;
   endfunction

   function automatic int rec_ts_lsb(input int cnt_w);
      return REC_MEM_LSB + 2 * cnt_w;
   endfunction

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_STOPPED = 2'd2;

endpackage

// File: rtl/godai_trace_fifo.sv
// rtl/godai_trace_fifo.sv - synchronous show-ahead FIFO with occupancy output
module godai_trace_fifo
   import godai_trace_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int LW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_full,
   output logic [LW-1:0]    o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [LW-1:0]    w_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Push into a full FIFO is only issued alongside a pop, so the slot written is the head being vacated.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   assign w_level = r_wptr - r_rptr;
   assign o_level = w_level;
   assign o_valid = (w_level != '0);
   assign o_full  = (w_level == LW'(DEPTH));
   assign o_data  = o_valid ? r_mem[r_rptr[AW-1:0]] : '0;

endmodule

// File: rtl/godai_trace_capture.sv
// rtl/godai_trace_capture.sv - timestamped core trace recorder; GODAI_TRACE_FILTER_EN adds event_mask_i
module godai_trace_capture
   import godai_trace_pkg::*;
#(
   parameter int  TS_WIDTH     = 32,
   parameter int  CNT_WIDTH    = 32,
   parameter int  DEPTH        = 16,
   parameter int  OVF_WIDTH    = 16,
   parameter bit  STOP_ON_FULL = 1'b0,
   localparam int REC_WIDTH    = TS_WIDTH + 2 * CNT_WIDTH + 8,
   localparam int LVL_WIDTH    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic                 jump_done_i,
   input  logic                 branch_decision_i,
   input  logic                 is_decoding_i,
   input  logic                 pc_set_i,
   input  logic                 branch_req_i,
   input  logic                 id_ready_i,
   input  logic [CNT_WIDTH-1:0] instr_count_i,
   input  logic [CNT_WIDTH-1:0] mem_req_count_i,
`ifdef GODAI_TRACE_FILTER_EN
   input  logic [5:0]           event_mask_i,
`endif
   output logic                 trace_valid_o,
   input  logic                 trace_ready_i,
   output logic [REC_WIDTH-1:0] trace_data_o,
   output logic [LVL_WIDTH-1:0] level_o,
   output logic [OVF_WIDTH-1:0] overflow_count_o,
   output logic                 stopped_o
);

   logic [1:0]           r_state;
   logic [TS_WIDTH-1:0]  r_ts;
   logic [CNT_WIDTH-1:0] r_last_mem;
   logic [OVF_WIDTH-1:0] r_ovf;
   logic                 r_marker;

   logic [5:0]           w_mask;
   logic [7:0]           w_flags;
   logic [REC_WIDTH-1:0] w_rec;
   logic                 w_run, w_event, w_push, w_pop, w_drop, w_full;

`ifdef GODAI_TRACE_FILTER_EN
   assign w_mask = event_mask_i;
`else
   assign w_mask = 6'h3F;
`endif

   always_comb begin
      w_flags              = '0;
      w_flags[FLAG_JUMP]   = jump_done_i;
      w_flags[FLAG_BRDEC]  = branch_decision_i;
      w_flags[FLAG_PCSET]  = pc_set_i;
      w_flags[FLAG_BRREQ]  = branch_req_i;
      w_flags[FLAG_DECODE] = is_decoding_i & id_ready_i;
      w_flags[FLAG_MEM]    = (mem_req_count_i != r_last_mem);
      w_flags[FLAG_RSVD]   = 1'b0;
      w_flags[FLAG_OVF]    = r_marker;
   end

   always_comb begin
      w_rec = '0;
      w_rec[REC_FLAGS_LSB +: 8]                   = w_flags;
      w_rec[REC_MEM_LSB +: CNT_WIDTH]             = mem_req_count_i;
      w_rec[rec_instr_lsb(CNT_WIDTH) +: CNT_WIDTH] = instr_count_i;
      w_rec[rec_ts_lsb(CNT_WIDTH) +: TS_WIDTH]     = r_ts;
   end

   // Masking gates only the capture decision; the stored flags keep every raw strobe.
   assign w_run   = (r_state == ST_RUN);
   assign w_event = w_run && ((w_flags[5:0] & w_mask) != 6'h00);
   assign w_pop   = trace_valid_o & trace_ready_i & ~clear_i;
   assign w_push  = w_event & (~w_full | w_pop) & ~clear_i;
   assign w_drop  = w_event & w_full & ~w_pop & ~clear_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ts       <= '0;
         r_last_mem <= '0;
         r_ovf      <= '0;
         r_marker   <= 1'b0;
      end else if (clear_i) begin
         r_state    <= ST_IDLE;
         r_ts       <= '0;
         r_last_mem <= '0;
         r_ovf      <= '0;
         r_marker   <= 1'b0;
      end else begin
         if (w_run) begin
            r_ts       <= r_ts + TS_WIDTH'(1);
            r_last_mem <= mem_req_count_i;
         end
         if (w_drop) begin
            if (r_ovf != '1) r_ovf <= r_ovf + OVF_WIDTH'(1);
            r_marker <= 1'b1;
         end else if (w_push) begin
            r_marker <= 1'b0;
         end
         case (r_state)
            ST_IDLE:    if (enable_i) r_state <= ST_RUN;
            ST_RUN: begin
               if (w_drop && STOP_ON_FULL) r_state <= ST_STOPPED;
               else if (!enable_i)         r_state <= ST_IDLE;
            end
            ST_STOPPED: r_state <= ST_STOPPED;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   godai_trace_fifo #(
      .WIDTH (REC_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (clear_i),
      .i_push  (w_push),
      .i_data  (w_rec),
      .i_pop   (w_pop),
      .o_data  (trace_data_o),
      .o_valid (trace_valid_o),
      .o_full  (w_full),
      .o_level (level_o)
   );

   assign overflow_count_o = r_ovf;
   assign stopped_o        = (r_state == ST_STOPPED);

endmodule

// File: tb/tb_godai_trace_capture.sv
// tb/tb_godai_trace_capture.sv - queue-model bench for godai_trace_capture
module tb_godai_trace_capture;

   localparam int TSW = 32, CW = 32, D = 16, OW = 16;
   localparam int RW = TSW + 2 * CW + 8, LW = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic enable = 0, clear = 0, ready = 0;
   logic sof_enable = 0, sof_clear = 0, sof_ready = 0;
   logic jump = 0, brdec = 0, isdec = 0, pcset = 0, brreq = 0, idrdy = 0;
   logic [CW-1:0] instr = '0, mem = '0;
   logic [5:0] mask = 6'h3F;

   logic          valid, stopped, s_valid, s_stopped;
   logic [RW-1:0] data, s_data;
   logic [LW-1:0] level, s_level;
   logic [OW-1:0] ovf, s_ovf;

   godai_trace_capture #(.STOP_ON_FULL(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .clear_i(clear),
      .jump_done_i(jump), .branch_decision_i(brdec), .is_decoding_i(isdec),
      .pc_set_i(pcset), .branch_req_i(brreq), .id_ready_i(idrdy),
      .instr_count_i(instr), .mem_req_count_i(mem),
`ifdef GODAI_TRACE_FILTER_EN
      .event_mask_i(mask),
`endif
      .trace_valid_o(valid), .trace_ready_i(ready), .trace_data_o(data),
      .level_o(level), .overflow_count_o(ovf), .stopped_o(stopped)
   );

   godai_trace_capture #(.STOP_ON_FULL(1'b1)) u_sof (
      .clk(clk), .rst_n(rst_n), .enable_i(sof_enable), .clear_i(sof_clear),
      .jump_done_i(jump), .branch_decision_i(brdec), .is_decoding_i(isdec),
      .pc_set_i(pcset), .branch_req_i(brreq), .id_ready_i(idrdy),
      .instr_count_i(instr), .mem_req_count_i(mem),
`ifdef GODAI_TRACE_FILTER_EN
      .event_mask_i(mask),
`endif
      .trace_valid_o(s_valid), .trace_ready_i(sof_ready), .trace_data_o(s_data),
      .level_o(s_level), .overflow_count_o(s_ovf), .stopped_o(s_stopped)
   );

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of records plus the capture rules, for the STOP_ON_FULL=0 instance.
   logic [RW-1:0] mq[$];
   bit            m_run = 0, m_mk = 0;
   logic [31:0]   m_ts = 0, m_last = 0;
   int            m_ovf = 0;

   always @(posedge clk or negedge rst_n) begin : model
      logic [5:0] fl;
      if (!rst_n || clear) begin
         mq.delete(); m_run = 0; m_mk = 0; m_ts = 0; m_last = 0; m_ovf = 0;
      end else begin
         fl = {mem != m_last, isdec & idrdy, brreq, pcset, brdec, jump};
         if (mq.size() > 0 && ready) void'(mq.pop_front());
         if (m_run && (fl & mask) != 6'h00) begin
            if (mq.size() < D) begin
               mq.push_back({m_ts, instr, mem, m_mk, 1'b0, fl});
               m_mk = 0;
            end else begin
               if (m_ovf < (1 << OW) - 1) m_ovf++;
               m_mk = 1;
            end
         end
         if (m_run) begin
            m_ts = m_ts + 1;
            m_last = mem;
         end
         if (!m_run && enable) m_run = 1;
         else if (m_run && !enable) m_run = 0;
      end
   end

   always @(negedge clk) begin : compare
      chk("valid", valid, mq.size() > 0);
      chk("level", level, mq.size());
      chk("overflow", ovf, m_ovf);
      chk("stopped", stopped, 0);
      if (mq.size() > 0) chk("data", data, mq[0]);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string name);
      ready = 1;
      for (int i = 0; i < 40 && level != 0; i++) cyc(1);
      ready = 0;
      chk(name, level, 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2 rst_n = 0;
      @(negedge clk);
      chk("rst_mid_level", level, 0);
      chk("rst_mid_valid", valid, 0);
      @(posedge clk); #2 rst_n = 1;
      @(negedge clk);
   endtask

   initial begin
      cyc(2);
      @(posedge clk); #2 rst_n = 1;
      @(negedge clk);
      chk("rst_valid", valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_data", data, 0);
      chk("rst_sof_stopped", s_stopped, 0);

      // First record: pc_set at ts=5
      enable = 1; instr = 32'h1234;
      cyc(6); pcset = 1; cyc(1); pcset = 0;
      chk("t1_valid", valid, 1);
      chk("t1_ts", data[103:72], 5);
      chk("t1_instr", data[71:40], 32'h1234);
      chk("t1_flags", data[7:0], 8'h04);
      chk("t1_level", level, 1);
      ready = 1; cyc(1); ready = 0;

      // Overflow: 16 accepted, 3 dropped
      jump = 1; cyc(19); jump = 0;
      chk("ovf_level", level, 16);
      chk("ovf_count", ovf, 3);
      drain("ovf_drain");
      jump = 1; cyc(1); jump = 0;
      chk("mark_flags", data[7:0], 8'h81);
      ready = 1; cyc(1); ready = 0;
      jump = 1; cyc(1); jump = 0;
      chk("mark_clear", data[7:0], 8'h01);

      // Full with simultaneous push and pop
      jump = 1; cyc(15);
      chk("pp_full", level, 16);
      ready = 1; cyc(1); jump = 0; ready = 0;
      chk("pp_level", level, 16);
      chk("pp_ovf", ovf, 3);
      drain("pp_drain");

      // Memory counter change alone
      mem = 7; cyc(3);
      drain("mem7_drain");
      mem = 8; cyc(1);
      chk("mem_level", level, 1);
      chk("mem_flags", data[7:0], 8'h20);
      chk("mem_field", data[39:8], 8);
      cyc(3);
      chk("mem_one", level, 1);
      drain("mem_drain");

`ifdef GODAI_TRACE_FILTER_EN
      mask = 6'h01;
      brreq = 1; cyc(1); brreq = 0; cyc(1);
      chk("filt_none", level, 0);
      jump = 1; brreq = 1; cyc(1); jump = 0; brreq = 0;
      chk("filt_one", level, 1);
      chk("filt_flags", data[7:0], 8'h09);
      drain("filt_drain");
      mask = 6'h3F;
`endif

      // STOP_ON_FULL instance
      ready = 1; sof_enable = 1; cyc(2);
      jump = 1; cyc(17); jump = 0;
      chk("sof_stopped", s_stopped, 1);
      chk("sof_level", s_level, 16);
      chk("sof_ovf", s_ovf, 1);
      sof_enable = 0; cyc(2); sof_enable = 1; jump = 1; cyc(2); jump = 0;
      chk("sof_hold_stopped", s_stopped, 1);
      chk("sof_hold_level", s_level, 16);
      sof_enable = 0; sof_clear = 1; cyc(1); sof_clear = 0;
      chk("sof_clr_level", s_level, 0);
      chk("sof_clr_stopped", s_stopped, 0);
      chk("sof_clr_ovf", s_ovf, 0);
      jump = 1; cyc(1); jump = 0; cyc(1);
      chk("sof_idle", s_level, 0);
      ready = 0;

      // Randomized traffic with phases of slow consumption, clears and one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) pulse_reset();
         enable = ($urandom % 16) != 0;
         clear  = ($urandom % 80) == 0;
         jump   = ($urandom % 4) == 0;
         brdec  = ($urandom % 6) == 0;
         pcset  = ($urandom % 8) == 0;
         brreq  = ($urandom % 6) == 0;
         isdec  = $urandom % 2;
         idrdy  = ($urandom % 3) == 0;
         instr  = $urandom;
         if (($urandom % 8) == 0) mem = mem + 1;
         ready  = ((i / 300) % 2 == 0) ? (($urandom % 2) == 0) : (($urandom % 8) == 0);
`ifdef GODAI_TRACE_FILTER_EN
         if (($urandom % 50) == 0) mask = 6'($urandom);
`endif
         cyc(1);
      end
      clear = 0; enable = 0; ready = 0;
      jump = 0; brdec = 0; pcset = 0; brreq = 0;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
